sincos_angle_decoder: RTL and testbench

SINCOS_ANGLE_DECODER -- requirements
Module: sincos_angle_decoder

---
 rtl/sincos_angle_decoder.sv | 157 +++++++++++++++
 tb/tb_sincos_angle_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sincos_angle_decoder.sv
// sincos_angle_decoder: inverse sin/cos lookup. A captured (sin, cos) pair is
// compared against the 16 table candidates (8 angles x 2 signs), two per cycle,
// and the candidate with the smallest L1 error is reported.
module sincos_angle_decoder (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [16:0] sin_in,
  input  logic signed [16:0] cos_in,
  output logic               busy,
  output logic               done,
  output logic        [2:0]  aci_out,
  output logic               eksi_out,
  output logic        [18:0] err_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic signed [16:0] sin_q, sin_d;
  logic signed [16:0] cos_q, cos_d;
  logic        [2:0]  k_q, k_d;
  logic        [18:0] best_err_q, best_err_d;
  logic        [2:0]  best_idx_q, best_idx_d;
  logic               best_sign_q, best_sign_d;
  logic               done_q, done_d;
  logic        [2:0]  aci_q, aci_d;
  logic               eksi_q, eksi_d;
  logic        [18:0] err_q, err_d;

  logic signed [16:0] tab_sin;
  logic signed [16:0] tab_cos;
  logic        [18:0] cand_err [2];

  // Q7.10 table for angle k*15 deg, indexed by the current search step.
  always_comb begin
    tab_sin = 17'sd0;
    tab_cos = 17'sd1024;
    case (k_q)
      3'd0: begin tab_sin = 17'sd0;    tab_cos = 17'sd1024;  end
      3'd1: begin tab_sin = 17'sd265;  tab_cos = 17'sd989;   end
      3'd2: begin tab_sin = 17'sd512;  tab_cos = 17'sd887;   end
      3'd3: begin tab_sin = 17'sd724;  tab_cos = 17'sd724;   end
      3'd4: begin tab_sin = 17'sd887;  tab_cos = 17'sd512;   end
      3'd5: begin tab_sin = 17'sd989;  tab_cos = 17'sd265;   end
      3'd6: begin tab_sin = 17'sd1024; tab_cos = 17'sd0;     end
      3'd7: begin tab_sin = 17'sd989;  tab_cos = -17'sd265;  end
      default: begin tab_sin = 17'sd0; tab_cos = 17'sd1024;  end
    endcase
  end

  // Two candidates per step: gi=0 uses +SIN, gi=1 uses -SIN; COS is shared.
  // Differences are 18-bit signed, magnitudes fit 18 bits, sum fits 19 bits.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cand
    localparam bit NEG = (gi != 0);
    logic signed [17:0] cand_sin;
    logic signed [17:0] diff_sin;
    logic signed [17:0] diff_cos;
    logic        [17:0] abs_sin;
    logic        [17:0] abs_cos;

    assign cand_sin    = NEG ? -18'(tab_sin) : 18'(tab_sin);
    assign diff_sin    = 18'(sin_q) - cand_sin;
    assign diff_cos    = 18'(cos_q) - 18'(tab_cos);
    assign abs_sin     = diff_sin[17] ? 18'(-diff_sin) : 18'(diff_sin);
    assign abs_cos     = diff_cos[17] ? 18'(-diff_cos) : 18'(diff_cos);
    assign cand_err[gi] = {1'b0, abs_sin} + {1'b0, abs_cos};
  end

  // Next-state and datapath: capture in IDLE, scan k in SEARCH, publish in DONE.
  always_comb begin
    state_d     = state_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    k_d         = k_q;
    best_err_d  = best_err_q;
    best_idx_d  = best_idx_q;
    best_sign_d = best_sign_q;
    done_d      = 1'b0;
    aci_d       = aci_q;
    eksi_d      = eksi_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sin_d       = sin_in;
          cos_d       = cos_in;
          k_d         = 3'd0;
          best_err_d  = '1;
          best_idx_d  = 3'd0;
          best_sign_d = 1'b0;
          state_d     = SEARCH;
        end
      end
      SEARCH: begin
        // Strict less-than keeps the earlier candidate on ties; e=0 is
        // checked before e=1 so it wins at equal k.
        if (cand_err[0] < best_err_d) begin
          best_err_d  = cand_err[0];
          best_idx_d  = k_q;
          best_sign_d = 1'b0;
        end
        if (cand_err[1] < best_err_d) begin
          best_err_d  = cand_err[1];
          best_idx_d  = k_q;
          best_sign_d = 1'b1;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        aci_d   = best_idx_q;
        eksi_d  = best_sign_q;
        err_d   = best_err_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sin_q       <= '0;
      cos_q       <= '0;
      k_q         <= '0;
      best_err_q  <= '0;
      best_idx_q  <= '0;
      best_sign_q <= 1'b0;
      done_q      <= 1'b0;
      aci_q       <= '0;
      eksi_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      k_q         <= k_d;
      best_err_q  <= best_err_d;
      best_idx_q  <= best_idx_d;
      best_sign_q <= best_sign_d;
      done_q      <= done_d;
      aci_q       <= aci_d;
      eksi_q      <= eksi_d;
      err_q       <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign aci_out  = aci_q;
  assign eksi_out = eksi_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_sincos_angle_decoder.sv
// Directed bench for sincos_angle_decoder: exact table hits, a non-exact pair,
// start flooding during busy, mid-search reset, and input toggling after capture.
module tb_sincos_angle_decoder;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [16:0] sin_in;
  logic signed [16:0] cos_in;
  logic               busy;
  logic               done;
  logic        [2:0]  aci_out;
  logic               eksi_out;
  logic        [18:0] err_out;

  int checks = 0;
  int errors = 0;

  sincos_angle_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sin_in   (sin_in),
    .cos_in   (cos_in),
    .busy     (busy),
    .done     (done),
    .aci_out  (aci_out),
    .eksi_out (eksi_out),
    .err_out  (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference search over all 16 candidates in index order, strict improvement.
  function automatic void golden(input int s, input int c,
                                 output int aci, output int eksi, output int err);
    int st [8] = '{0, 265, 512, 724, 887, 989, 1024, 989};
    int ct [8] = '{1024, 989, 887, 724, 512, 265, 0, -265};
    int cs, ds, dc, d;
    err = 32'h7fffffff; aci = 0; eksi = 0;
    for (int k = 0; k < 8; k++) begin
      for (int e = 0; e < 2; e++) begin
        cs = (e == 1) ? -st[k] : st[k];
        ds = s - cs; if (ds < 0) ds = -ds;
        dc = c - ct[k]; if (dc < 0) dc = -dc;
        d = ds + dc;
        if (d < err) begin err = d; aci = k; eksi = e; end
      end
    end
  endfunction

  // Called #1 after a rising edge; returns #1 after the done edge.
  task automatic run_op(input string tag, input int s, input int c, input bit scramble,
                        input int exp_aci, input int exp_eksi, input int exp_err);
    int n;
    sin_in = 17'(s);
    cos_in = 17'(c);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    while (!done && n < 20) begin
      if (scramble) begin
        sin_in = 17'($urandom);
        cos_in = 17'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd10);
    chk({tag, "_aci"}, 32'(aci_out), 32'(exp_aci));
    chk({tag, "_eksi"}, 32'(eksi_out), 32'(exp_eksi));
    chk({tag, "_err"}, 32'(err_out), 32'(exp_err));
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    $display("op %s sin=%0d cos=%0d -> aci=%0d eksi=%0d err=%0d latency=%0d",
             tag, s, c, aci_out, eksi_out, err_out, n);
  endtask

  initial begin
    int st [8] = '{0, 265, 512, 724, 887, 989, 1024, 989};
    int ct [8] = '{1024, 989, 887, 724, 512, 265, 0, -265};
    int dones, busy_cnt, done1, done2, ga, ge, gr, s, c;

    reset = 1'b1; start = 1'b0; sin_in = '0; cos_in = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aci", 32'(aci_out), 32'd0);
    chk("rst_eksi", 32'(eksi_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Exact and non-exact directed cases, back-to-back.
    run_op("t1_zero", 0, 1024, 1'b0, 0, 0, 0);
    run_op("t2_neg60", -887, 512, 1'b0, 4, 1, 0);
    run_op("t2_105", 989, -265, 1'b0, 7, 0, 0);
    // (600,800): k=2 gives |600-512|+|800-887| = 175, below k=3's 200.
    run_op("t3_nonexact", 600, 800, 1'b0, 2, 0, 175);

    // Hold start high through two accept points while inputs change.
    sin_in = 17'sd265; cos_in = 17'sd989; start = 1'b1;
    dones = 0; busy_cnt = 0; done1 = 0; done2 = 0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) sin_in = -17'sd265;
      if (cyc == 11) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          done1 = cyc;
          chk("t4_first_aci", 32'(aci_out), 32'd1);
          chk("t4_first_eksi", 32'(eksi_out), 32'd0);
          chk("t4_first_busy", 32'(busy), 32'd0);
        end else begin
          done2 = cyc;
          chk("t4_second_aci", 32'(aci_out), 32'd1);
          chk("t4_second_eksi", 32'(eksi_out), 32'd1);
        end
      end
    end
    chk("t4_done_count", 32'(dones), 32'd2);
    chk("t4_done1_cycle", 32'(done1), 32'd10);
    chk("t4_done2_cycle", 32'(done2), 32'd20);
    chk("t4_busy_cycles", 32'(busy_cnt), 32'd18);
    $display("op t4_flood dones=%0d busy_cycles=%0d done_at=%0d,%0d", dones, busy_cnt, done1, done2);

    // Leave non-zero outputs, then reset in the 4th SEARCH cycle.
    run_op("t5_pre", 600, 800, 1'b0, 2, 0, 175);
    sin_in = 17'sd512; cos_in = 17'sd887; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_aci", 32'(aci_out), 32'd0);
    chk("t5_eksi", 32'(eksi_out), 32'd0);
    chk("t5_err", 32'(err_out), 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    dones = 0; busy_cnt = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) busy_cnt++;
    end
    chk("t5_no_done", 32'(dones), 32'd0);
    chk("t5_idle", 32'(busy_cnt), 32'd0);
    $display("op t5_reset dones_after=%0d busy_after=%0d", dones, busy_cnt);
    run_op("t5_after", 512, 887, 1'b0, 2, 0, 0);

    // Inputs toggled during SEARCH; result follows the captured pair.
    for (int i = 0; i < 4; i++) begin
      s = int'($urandom_range(0, 4000)) - 2000;
      c = int'($urandom_range(0, 4000)) - 2000;
      golden(s, c, ga, ge, gr);
      run_op($sformatf("t6_rand%0d", i), s, c, 1'b1, ga, ge, gr);
    end

    // All 16 exact table pairs; -0 at k=0 ties with +0 and keeps e=0.
    for (int k = 0; k < 8; k++) begin
      for (int e = 0; e < 2; e++) begin
        run_op($sformatf("t6_k%0d_e%0d", k, e), (e == 1) ? -st[k] : st[k], ct[k], 1'b1,
               k, (e == 1 && k != 0) ? 1 : 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
